// File: rtl/uart_bus_pkg.sv
// Shared command bytes, reply codes and state encodings for the UART-to-bus bridge.
package uart_bus_pkg;

    localparam logic [7:0] CMD_WRITE = 8'hA5;
    localparam logic [7:0] CMD_READ  = 8'h5A;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    typedef enum logic [2:0] {
        P_CMD,
        P_ADDR,
        P_DATA,
        P_BUS,
        P_RESP
    } parse_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, glitch rejection on the start bit,
// one-cycle rx_valid / rx_frame_err pulses in the cycle after the stop-bit sample.
module uart_rx_byte
    import uart_bus_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(BAUD_DIV - 1);

    logic [1:0]  sync_q;
    logic        prev_q;
    logic        rx_s;
    rx_state_e   st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_pin};
            prev_q  <= rx_s;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (st_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    st_d  = RX_START;
                    cnt_d = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    // A line already back high at mid-start is a glitch.
                    st_d  = rx_s ? RX_IDLE : RX_DATA;
                    cnt_d = '0;
                    bit_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        st_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = err_q;

endmodule

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: parses write/read command frames, runs one bus transfer, replies over TX.
// Optional inter-byte frame timeout enabled by defining UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int unsigned BAUD_DIV      = 434,
    parameter int unsigned FRAME_TIMEOUT = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic        ready_i,
    input  logic [31:0] data_i,
    output logic        busy_o
);

    localparam logic [15:0] BIT_M1 = 16'(BAUD_DIV - 1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    uart_rx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_pin      (rx_pin),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    parse_state_e state_q, state_d;
    logic         we_q, we_d;
    logic [1:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  data_q, data_d;
    logic         req_q, req_d;
    logic [31:0]  resp_q, resp_d;
    logic [2:0]   resp_left_q, resp_left_d;
    logic         tx_q, tx_d;
    logic         tx_active_q, tx_active_d;
    logic [3:0]   tx_bit_q, tx_bit_d;
    logic [15:0]  tx_baud_q, tx_baud_d;
    logic [7:0]   tx_byte_q, tx_byte_d;
    logic         load_tx;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    logic [31:0] to_cnt_q;
    logic        in_frame;
    logic        to_expired;

    assign in_frame   = (state_q == P_ADDR) || (state_q == P_DATA);
    assign to_expired = in_frame && !rx_valid && (to_cnt_q == 32'(FRAME_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !in_frame || rx_valid || to_expired) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end
`else
    logic unused_frame_timeout;
    assign unused_frame_timeout = ^FRAME_TIMEOUT;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= P_CMD;
            we_q        <= 1'b0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            req_q       <= 1'b0;
            resp_q      <= '0;
            resp_left_q <= '0;
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_bit_q    <= '0;
            tx_baud_q   <= '0;
            tx_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            req_q       <= req_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            tx_q        <= tx_d;
            tx_active_q <= tx_active_d;
            tx_bit_q    <= tx_bit_d;
            tx_baud_q   <= tx_baud_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        req_d       = req_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        tx_d        = tx_q;
        tx_active_d = tx_active_q;
        tx_bit_d    = tx_bit_q;
        tx_baud_d   = tx_baud_q;
        tx_byte_d   = tx_byte_q;
        load_tx     = 1'b0;
        unique case (state_q)
            P_CMD: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        we_d       = (rx_data == CMD_WRITE);
                        byte_cnt_d = '0;
                        state_d    = P_ADDR;
                    end else begin
                        resp_d      = {24'h0, RSP_ERR};
                        resp_left_d = 3'd1;
                        state_d     = P_RESP;
                    end
                end
            end
            P_ADDR: begin
                if (rx_frame_err) begin
                    state_d = P_CMD;
                end else if (rx_valid) begin
                    addr_d     = {rx_data, addr_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (we_q) begin
                            state_d = P_DATA;
                        end else begin
                            state_d = P_BUS;
                            req_d   = 1'b1;
                        end
                    end
                end
            end
            P_DATA: begin
                if (rx_frame_err) begin
                    state_d = P_CMD;
                end else if (rx_valid) begin
                    data_d     = {rx_data, data_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = P_BUS;
                        req_d   = 1'b1;
                    end
                end
            end
            P_BUS: begin
                if (req_q && ready_i) begin
                    req_d   = 1'b0;
                    state_d = P_RESP;
                    if (we_q) begin
                        resp_d      = {24'h0, RSP_OK};
                        resp_left_d = 3'd1;
                    end else begin
                        resp_d      = data_i;
                        resp_left_d = 3'd4;
                    end
                end
            end
            P_RESP: begin
                if (!tx_active_q) begin
                    load_tx = 1'b1;
                end else if (tx_baud_q == BIT_M1) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        // End of stop bit: chain the next byte with no idle gap.
                        if (resp_left_q != 3'd0) begin
                            load_tx = 1'b1;
                        end else begin
                            tx_active_d = 1'b0;
                            state_d     = P_CMD;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : tx_byte_q[tx_bit_q[2:0]];
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 16'd1;
                end
            end
            default: state_d = P_CMD;
        endcase

        if (load_tx) begin
            tx_byte_d   = resp_q[7:0];
            resp_d      = {8'h00, resp_q[31:8]};
            resp_left_d = resp_left_q - 3'd1;
            tx_active_d = 1'b1;
            tx_bit_d    = '0;
            tx_baud_d   = '0;
            tx_d        = 1'b0;
        end

`ifdef UART_BUS_MASTER_TIMEOUT_EN
        if (to_expired) begin
            state_d = P_CMD;
        end
`endif
    end

    assign tx_pin = tx_q;
    assign req_o  = req_q;
    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
    assign busy_o = (state_q != P_CMD) || tx_active_q;

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-to-bus bridge. Receives command frames on rx_pin and issues single-word transactions as initiator on the peripheral bus (req/we/addr/data/ready).
- Returns status or read data on tx_pin.
- Gives a host PC (or test harness) debug and load access to memory and peripherals, including the UART peripheral's own registers.
- Line format fixed: 8N1, LSB first, idle high.

Parameters:
- BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 4..65535.
- FRAME_TIMEOUT, 1000000, max idle cycles between bytes of one frame (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active high.
- rx_pin  in  1  serial input, asynchronous to clk_i.
- tx_pin  out  1  serial output.
- req_o  out  1  bus request.
- we_o  out  1  bus write enable (1 = write).
- addr_o  out  32  bus address.
- data_o  out  32  bus write data.
- ready_i  in  1  responder ready; transfer completes on a clock edge where req_o && ready_i.
- data_i  in  32  bus read data, sampled on the completing edge.
- busy_o  out  1  high while a frame is in progress (parser not in P_CMD) or TX is active.

Behaviour:
- Reset: synchronous on rst_i. Output values: tx_pin=1, req_o=0, we_o=0, addr_o=0, data_o=0, busy_o=0. Parser goes to P_CMD, RX to idle.
- Reset mid-byte or mid-transaction aborts immediately. tx_pin returns high on the first clock after reset is sampled. No partial reply resumes.
- RX input: rx_pin passes through a 2-FF synchronizer, reset value 1.
- Start detection: a falling edge on the synchronized line, in RX idle, starts a byte.
- Sampling: start bit sampled at BAUD_DIV/2 (integer floor). If the line is high there, the byte is a glitch: return to RX idle, nothing is delivered.
- Data and stop bits: 8 data bits are then sampled every BAUD_DIV cycles, LSB first, followed by the stop bit.
- Stop bit 0 is a framing error. The byte is discarded and the parser returns to P_CMD with no reply.
- Byte delivery: a valid byte produces a 1-cycle rx_valid pulse in the cycle after the stop-bit sample.
- Frame formats (multi-byte fields LSB first):
  - Write: 0xA5, addr[4], data[4].
  - Read: 0x5A, addr[4].
- Parser states: P_CMD, P_ADDR, P_DATA, P_BUS, P_RESP.
  - P_CMD:
    - 0xA5 or 0x5A: latch we, clear the byte counter, go to P_ADDR.
    - Any other byte: queue reply 0x45 ('E'), go to P_RESP.
  - P_ADDR: shift bytes into addr. After byte 4: write goes to P_DATA, read goes to P_BUS.
  - P_DATA: shift bytes into data. After byte 4: go to P_BUS.
  - P_BUS:
    - req_o rises in the cycle after the last byte's rx_valid.
    - req_o, we_o, addr_o and data_o stay stable until the completing edge.
    - req_o is 0 in the cycle after completion.
    - If ready_i is already high, the transfer completes in 1 cycle.
    - On a read, data_i is captured on the completing edge. Then go to P_RESP.
  - P_RESP: transmit the reply, then go to P_CMD in the cycle after the last stop bit ends.
    - Write reply: 0x4B ('K').
    - Read reply: data[7:0], [15:8], [23:16], [31:24].
- TX timing:
  - Each byte is start bit, 8 data bits, stop bit, each exactly BAUD_DIV cycles.
  - Bytes are back-to-back, with no extra idle between them.
  - The start bit of the first reply byte begins 1 cycle after P_RESP entry.
- Bytes received while in P_BUS or P_RESP are dropped silently. The host must wait for the reply.
- addr_o and data_o hold their last values between frames; they are don't-care while req_o=0.
- No bus timeout: the block waits on ready_i indefinitely.

Optional Feature:
- Macro: UART_BUS_MASTER_TIMEOUT_EN.
- With the macro defined:
  - In P_ADDR or P_DATA, a counter counts cycles since the last rx_valid.
  - Reaching FRAME_TIMEOUT discards the partial frame and returns to P_CMD with no reply.
  - Any rx_valid, or entry to P_CMD, clears the counter.
- Without the macro: no counter. A partial frame waits indefinitely for its remaining bytes.

Decomposition:
- Package uart_bus_pkg holds:
  - CMD_WRITE=8'hA5, CMD_READ=8'h5A, RSP_OK=8'h4B, RSP_ERR=8'h45.
  - Parser state enum parse_state_e (P_CMD..P_RESP).
  - RX state enum (RX_IDLE, RX_START, RX_DATA, RX_STOP).
- One sub-module, uart_rx_byte: synchronizer, bit counter, baud counter and RX FSM. It outputs rx_data[7:0], rx_valid and rx_frame_err.
- The TX serializer and parser stay inline in uart_bus_master.

Test Plan:
- All tests run with BAUD_DIV=8.
- Write: send A5 10 00 00 00 EF BE AD DE -> req_o=1, we_o=1, addr_o=0x00000010, data_o=0xDEADBEEF. Hold ready_i=0 for 5 cycles, then 1 -> req_o drops the cycle after the completing edge; tx_pin emits 0x4B.
- Read: send 5A 10 00 00 00; ready_i=1 with data_i=0x12345678 -> exactly one we_o=0 transfer; tx emits 78 56 34 12 back-to-back, 40*8 cycles total.
- Bad command: send 0x33 -> no req_o; tx emits 0x45; the next A5 frame is accepted normally.
- Framing error: send A5, then a byte with stop bit 0 -> parser back in P_CMD, no reply; a subsequent valid read frame succeeds.
- Glitch and reset:
  - 2-cycle low pulse on rx_pin -> no byte delivered.
  - Assert rst_i mid-reply -> tx_pin=1 next cycle, busy_o=0, req_o=0.
- Timeout (macro defined): with FRAME_TIMEOUT=200, send A5 10, then idle 250 cycles, then a complete read frame -> only the read executes; no write occurs.
